// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master issues operations; the slave (the adder) returns busy/done and the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. A single full-adder cell consumes one operand
// bit per clock, LSB first, with the running carry held in a flip-flop.
// Operation: IDLE/DONE accepts start -> RUN for WIDTH cycles -> DONE (one-cycle
// done pulse). The result registers hold their value until the next completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;

  logic             load, shift, finish;
  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] acc_next;

  // Full-adder cell: gate-level sum and majority carry on the current bit pair.
  assign fa_sum   = a_sr[0] ^ b_sr[0] ^ cy;
  assign fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & cy) | (b_sr[0] & cy);

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign acc_next = {fa_sum, acc[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (cnt == LAST_BIT) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Back-to-back: a start seen during the done pulse reloads immediately.
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand shift registers, running carry, bit counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the working registers are reset too, so an aborted operation
    // leaves no stale partial result behind.
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
    end else if (load) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      cy   <= bus.c_in;
      cnt  <= '0;
    end else if (shift) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      cy   <= fa_carry;
      cnt  <= cnt + CNT_W'(1);
      acc  <= acc_next;
    end
  end

  // Result registers: updated only on the final RUN edge, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else if (finish) begin
      sum_q   <= acc_next;
      c_out_q <= fa_carry;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH = 8). Stimulus pushes the
// expected {c_out, sum} into a scoreboard queue; a monitor pops and compares
// on every done pulse.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard, required no done (t=%0t)", $time);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", 32'({bus.c_out, bus.sum}), 32'(e));
      end
    end
  end

  // Drive one accepted operation; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input bit push);
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = ci;
    bus.start = 1'b1;
    if (push) exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(ci));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for the done pulse, then let the DONE cycle end.
  task automatic wait_done();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) break;
    end
    if (k == 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 40 cycles, required done (t=%0t)", $time);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int done_at;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({bus.busy, bus.done, bus.c_out, bus.sum}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0 + 0: busy for 8 cycles, done in the 9th cycle after start.
    issue(8'h00, 8'h00, 1'b0, 1'b1);
    busy_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_at = k;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    check("done_latency", 32'(done_at), 32'd9);
    @(posedge clk);
    #1;
    check("idle_after_done", 32'({bus.busy, bus.done}), 32'h0);

    // Wrap-around and full carry ripple.
    issue(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done();
    issue(8'hA5, 8'h5A, 1'b1, 1'b1);
    wait_done();

    // Result must hold the previous value (0x00 / carry 1) throughout RUN.
    issue(8'h3C, 8'h42, 1'b1, 1'b1);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("hold_during_run", 32'({bus.busy, bus.c_out, bus.sum}), 32'h300);
    end
    wait_done();
    check("hold_in_idle", 32'({bus.c_out, bus.sum}), 32'h07F);

    // Back-to-back with start held high; operands wiggle during RUN.
    bus.a = 8'h12; bus.b = 8'h34; bus.c_in = 1'b0; bus.start = 1'b1;
    exp_q.push_back(9'h046);
    @(posedge clk);
    #1;
    for (int k = 0; k < W; k++) begin
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.c_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus.a = 8'hC8; bus.b = 8'h64; bus.c_in = 1'b1;
    exp_q.push_back(9'h12D);
    @(negedge clk);
    check("b2b_done_pulse", 32'({bus.busy, bus.done}), 32'h1);
    @(posedge clk);
    #1;
    bus.a = 8'h00; bus.b = 8'hFF; bus.c_in = 1'b1;
    @(negedge clk);
    check("b2b_busy_reasserts", 32'({bus.busy, bus.done}), 32'h2);
    for (int k = 1; k < W; k++) begin
      @(posedge clk);
      #1;
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.c_in = 1'($urandom);
    end
    @(posedge clk);
    #1;
    bus.a = 8'h80; bus.b = 8'h80; bus.c_in = 1'b0;
    exp_q.push_back(9'h100);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();

    // Reset in the middle of RUN aborts the operation with no done pulse.
    issue(8'hFF, 8'hFF, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({bus.busy, bus.done, bus.c_out, bus.sum}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_stays_idle", 32'({bus.busy, bus.done, bus.c_out, bus.sum}), 32'h0);
    @(posedge clk);
    #1;
    issue(8'h01, 8'h02, 1'b0, 1'b1);
    wait_done();

    // Random operations.
    for (int i = 0; i < 500; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      wait_done();
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
